// File: rtl/sd_sector_buf_if.sv
// Host byte bus plus sd_controller byte handshake for the sector buffer.
// master = host/controller side, slave = sd_sector_buf.
interface sd_sector_buf_if;
  logic [8:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_we;
  logic [7:0]  host_rdata;
  logic [31:0] sector;
  logic        cmd_rd;
  logic        cmd_wr;
  logic        busy;
  logic        done;
  logic        err;
  logic        sd_rd;
  logic        sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_din;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;
  logic        sd_ready;
  logic        sd_ready_for_next_byte;

  modport master (
    output host_addr, host_wdata, host_we, sector, cmd_rd, cmd_wr,
           sd_dout, sd_byte_available, sd_ready, sd_ready_for_next_byte,
    input  host_rdata, busy, done, err, sd_rd, sd_wr, sd_address, sd_din
  );

  modport slave (
    input  host_addr, host_wdata, host_we, sector, cmd_rd, cmd_wr,
           sd_dout, sd_byte_available, sd_ready, sd_ready_for_next_byte,
    output host_rdata, busy, done, err, sd_rd, sd_wr, sd_address, sd_din
  );
endinterface

// File: rtl/sd_sector_buf.sv
// 512-byte sector buffer that streams one whole sector to/from the sd_controller
// on a single host command, with done/err reporting and a progress watchdog.
module sd_sector_buf #(
  parameter bit          BYTE_ADDR      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic           clk_25mhz,
  input  logic           rst,
  sd_sector_buf_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_RD_REQ, S_RD_DATA, S_WR_PRE, S_WR_REQ, S_WR_DATA, S_FINISH
  } state_t;

  state_t      r_state;
  logic        r_is_rd;
  logic [9:0]  r_cnt;
  logic [TW-1:0] r_tmo;
  logic        r_rdy_q, r_ba_q, r_nb_q;
  logic        r_busy, r_done, r_err, r_sd_rd, r_sd_wr;
  logic [31:0] r_addr;
  logic [7:0]  r_din, r_rdata;
  logic [7:0]  r_mem [512];

  logic        w_ba_rise, w_nb_rise, w_progress, w_cmd, w_ram_we, w_tmo_live;
  logic [8:0]  w_ram_addr;
  logic [7:0]  w_ram_wd;

  assign w_ba_rise  = bus.sd_byte_available & ~r_ba_q;
  assign w_nb_rise  = bus.sd_ready_for_next_byte & ~r_nb_q;
  assign w_progress = (bus.sd_ready ^ r_rdy_q) | w_ba_rise | w_nb_rise;
  assign w_cmd      = bus.cmd_rd | bus.cmd_wr;
  assign w_tmo_live = (r_state != S_IDLE) && (r_state != S_FINISH);

  // Host owns the RAM port in IDLE; otherwise the byte counter drives it.
  // r_cnt[9] set means 512 bytes done, so it also gates further writes.
  assign w_ram_addr = (r_state == S_IDLE) ? bus.host_addr : r_cnt[8:0];
  assign w_ram_we   = ((r_state == S_IDLE) && bus.host_we) ||
                      ((r_state == S_RD_DATA) && w_ba_rise && !r_cnt[9]);
  assign w_ram_wd   = (r_state == S_IDLE) ? bus.host_wdata : bus.sd_dout;

  always_ff @(posedge clk_25mhz) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wd;
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_is_rd <= 1'b0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_rdy_q <= 1'b0;
      r_ba_q  <= 1'b0;
      r_nb_q  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_sd_rd <= 1'b0;
      r_sd_wr <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rdata <= '0;
    end else begin
      r_rdy_q <= bus.sd_ready;
      r_ba_q  <= bus.sd_byte_available;
      r_nb_q  <= bus.sd_ready_for_next_byte;
      r_done  <= 1'b0;

      if (r_state != S_IDLE) begin
        if (w_progress)      r_tmo <= TMO_LOAD;
        else if (r_tmo != 0) r_tmo <= r_tmo - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_rdata <= r_mem[w_ram_addr];
          if (w_cmd) begin
            r_is_rd <= bus.cmd_rd;
            r_addr  <= BYTE_ADDR ? {bus.sector[22:0], 9'd0} : bus.sector;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_tmo   <= TMO_LOAD;
            r_state <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: if (bus.sd_ready) begin
          if (r_is_rd) begin
            r_sd_rd <= 1'b1;
            r_state <= S_RD_REQ;
          end else begin
            r_state <= S_WR_PRE;
          end
        end
        S_RD_REQ: if (!bus.sd_ready) begin
          r_sd_rd <= 1'b0;
          r_state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (w_ba_rise && !r_cnt[9]) r_cnt <= r_cnt + 1'b1;
          if (bus.sd_ready) r_state <= S_FINISH;
        end
        S_WR_PRE: begin
          r_din   <= r_mem[w_ram_addr];
          r_sd_wr <= 1'b1;
          r_state <= S_WR_REQ;
        end
        S_WR_REQ: if (!bus.sd_ready) begin
          r_sd_wr <= 1'b0;
          r_state <= S_WR_DATA;
        end
        S_WR_DATA: begin
          // Refetch every cycle so sd_din follows the counter one cycle later.
          r_din <= r_mem[w_ram_addr];
          if (w_nb_rise && !r_cnt[9]) r_cnt <= r_cnt + 1'b1;
          if (bus.sd_ready) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_is_rd ? (r_cnt == 10'd512) : (r_cnt >= 10'd511)) r_done <= 1'b1;
          else                                                   r_err  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase

      // Fires on the cycle the count would reach 0, i.e. TIMEOUT_CYCLES edges after the reload.
      if (w_tmo_live && !w_progress && r_tmo <= TW'(1)) begin
        r_err   <= 1'b1;
        r_sd_rd <= 1'b0;
        r_sd_wr <= 1'b0;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.host_rdata = r_rdata;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.sd_rd      = r_sd_rd;
  assign bus.sd_wr      = r_sd_wr;
  assign bus.sd_address = r_addr;
  assign bus.sd_din     = r_din;
endmodule

// File: tb/tb_sd_sector_buf.sv
// Directed bench for sd_sector_buf: block-addressed (u_dut_hc) and byte-addressed
// (u_dut_sc) instances see identical stimulus; a procedural sd_controller model drives both.
module tb_sd_sector_buf;
  logic clk_25mhz = 1'b0;
  logic rst = 1'b1;
  always #20 clk_25mhz = ~clk_25mhz;

  sd_sector_buf_if bus0();
  sd_sector_buf_if bus1();

  assign bus1.host_addr              = bus0.host_addr;
  assign bus1.host_wdata             = bus0.host_wdata;
  assign bus1.host_we                = bus0.host_we;
  assign bus1.sector                 = bus0.sector;
  assign bus1.cmd_rd                 = bus0.cmd_rd;
  assign bus1.cmd_wr                 = bus0.cmd_wr;
  assign bus1.sd_dout                = bus0.sd_dout;
  assign bus1.sd_byte_available      = bus0.sd_byte_available;
  assign bus1.sd_ready               = bus0.sd_ready;
  assign bus1.sd_ready_for_next_byte = bus0.sd_ready_for_next_byte;

  sd_sector_buf #(.BYTE_ADDR(1'b0), .TIMEOUT_CYCLES(1000)) u_dut_hc (
    .clk_25mhz(clk_25mhz), .rst(rst), .bus(bus0));
  sd_sector_buf #(.BYTE_ADDR(1'b1), .TIMEOUT_CYCLES(1000)) u_dut_sc (
    .clk_25mhz(clk_25mhz), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25mhz);
  endtask

  function automatic logic sig(input int w);
    case (w)
      0:       return bus0.sd_rd;
      1:       return bus0.sd_wr;
      default: return bus0.busy;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input logic v, input int lim);
    int n = 0;
    while (sig(w) !== v && n < lim) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(sig(w)), 32'(v));
  endtask

  task automatic pulse_cmd(input logic rd, input logic wr, input logic [31:0] sec);
    bus0.sector = sec;
    bus0.cmd_rd = rd;
    bus0.cmd_wr = wr;
    tick(1);
    bus0.cmd_rd = 1'b0;
    bus0.cmd_wr = 1'b0;
  endtask

  task automatic host_rd(input string tag, input logic [8:0] a, input logic [7:0] exp);
    bus0.host_addr = a;
    tick(1);
    chk(tag, 32'(bus0.host_rdata), 32'(exp));
  endtask

  task automatic count_done(input int n, output int np);
    np = 0;
    repeat (n) begin
      tick(1);
      if (bus0.done === 1'b1) np++;
    end
  endtask

  task automatic rd_model(input int nbytes, input logic [7:0] key, input logic fin);
    wait_for("rd_req", 0, 1'b1, 20);
    tick(3);
    chk("rd_hold", 32'(bus0.sd_rd), 32'd1);
    bus0.sd_ready = 1'b0;
    wait_for("rd_drop", 0, 1'b0, 4);
    for (int k = 0; k < nbytes; k++) begin
      bus0.sd_dout = key ^ 8'(k);
      bus0.sd_byte_available = 1'b1;
      tick(2);
      bus0.sd_byte_available = 1'b0;
      tick(1);
    end
    if (fin) bus0.sd_ready = 1'b1;
  endtask

  task automatic wr_model();
    int bad = 0;
    int np;
    wait_for("wr_req", 1, 1'b1, 20);
    tick(3);
    chk("wr_hold", 32'(bus0.sd_wr), 32'd1);
    bus0.sd_ready = 1'b0;
    wait_for("wr_drop", 1, 1'b0, 4);
    for (int k = 0; k < 512; k++) begin
      if (bus0.sd_din !== 8'(k)) bad++;
      bus0.sd_ready_for_next_byte = 1'b1;
      tick(2);
      bus0.sd_ready_for_next_byte = 1'b0;
      tick(2);
    end
    chk("wr_bytes_bad", 32'(bad), 32'd0);
    bus0.sd_ready = 1'b1;
    count_done(10, np);
    chk("wr_done_cnt", 32'(np), 32'd1);
  endtask

  initial begin
    #(100000 * 40);
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np;
    bus0.host_addr = '0;
    bus0.host_wdata = '0;
    bus0.host_we = 1'b0;
    bus0.sector = '0;
    bus0.cmd_rd = 1'b0;
    bus0.cmd_wr = 1'b0;
    bus0.sd_dout = '0;
    bus0.sd_byte_available = 1'b0;
    bus0.sd_ready = 1'b1;
    bus0.sd_ready_for_next_byte = 1'b0;

    // Reset values, sampled while reset is still held
    tick(3);
    chk("rst_busy",  32'(bus0.busy), 32'd0);
    chk("rst_done",  32'(bus0.done), 32'd0);
    chk("rst_err",   32'(bus0.err), 32'd0);
    chk("rst_sd_rd", 32'(bus0.sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(bus0.sd_wr), 32'd0);
    chk("rst_din",   32'(bus0.sd_din), 32'd0);
    chk("rst_addr",  bus0.sd_address, 32'd0);
    chk("rst_rdata", 32'(bus0.host_rdata), 32'd0);
    rst = 1'b0;
    tick(1);

    // Host fill RAM[i] = i[7:0]
    for (int i = 0; i < 512; i++) begin
      bus0.host_addr = 9'(i);
      bus0.host_wdata = 8'(i);
      bus0.host_we = 1'b1;
      tick(1);
    end
    bus0.host_we = 1'b0;
    host_rd("host_rd5", 9'd5, 8'h05);
    host_rd("host_rd300", 9'd300, 8'h2C);

    // Sector write, sector 3
    pulse_cmd(1'b0, 1'b1, 32'd3);
    chk("wr_busy", 32'(bus0.busy), 32'd1);
    chk("wr_addr_blk", bus0.sd_address, 32'h3);
    chk("wr_addr_byte", bus1.sd_address, 32'h600);
    wr_model();
    chk("wr_err", 32'(bus0.err), 32'd0);
    chk("wr_busy_end", 32'(bus0.busy), 32'd0);

    // Simultaneous rd+wr => read; wr during busy dropped
    pulse_cmd(1'b1, 1'b1, 32'h10);
    chk("rd_addr_blk", bus0.sd_address, 32'h10);
    chk("rd_addr_byte", bus1.sd_address, 32'h2000);
    pulse_cmd(1'b0, 1'b1, 32'h99);
    chk("busy_cmd_addr", bus0.sd_address, 32'h10);
    chk("rd_no_wr", 32'(bus0.sd_wr), 32'd0);
    rd_model(512, 8'hAA, 1'b1);
    count_done(10, np);
    chk("rd_done_cnt", 32'(np), 32'd1);
    chk("rd_err", 32'(bus0.err), 32'd0);
    chk("rd_sd_wr", 32'(bus0.sd_wr), 32'd0);
    chk("rd_busy_end", 32'(bus0.busy), 32'd0);
    host_rd("rd_ram0", 9'd0, 8'hAA);
    host_rd("rd_ram511", 9'd511, 8'h55);

    // Short read (200 bytes) with a host write attempted while busy
    pulse_cmd(1'b1, 1'b0, 32'h20);
    bus0.host_addr = 9'd400;
    bus0.host_wdata = 8'h77;
    bus0.host_we = 1'b1;
    tick(1);
    bus0.host_we = 1'b0;
    rd_model(200, 8'h5A, 1'b1);
    count_done(10, np);
    chk("short_done_cnt", 32'(np), 32'd0);
    chk("short_err", 32'(bus0.err), 32'd1);
    chk("short_busy", 32'(bus0.busy), 32'd0);
    host_rd("short_ram10", 9'd10, 8'h50);
    host_rd("short_ram199", 9'd199, 8'h9D);
    host_rd("short_ram200", 9'd200, 8'h62);
    host_rd("busy_we_ram400", 9'd400, 8'h3A);

    // Next command clears err; reset after 100 bytes
    pulse_cmd(1'b1, 1'b0, 32'h30);
    chk("err_clear", 32'(bus0.err), 32'd0);
    rd_model(100, 8'h11, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_busy", 32'(bus0.busy), 32'd0);
    chk("mid_rst_sd_rd", 32'(bus0.sd_rd), 32'd0);
    chk("mid_rst_done", 32'(bus0.done), 32'd0);
    rst = 1'b0;
    bus0.sd_ready = 1'b1;
    count_done(10, np);
    chk("mid_rst_no_done", 32'(np), 32'd0);

    // Recovery read completes normally
    pulse_cmd(1'b1, 1'b0, 32'h40);
    rd_model(512, 8'h33, 1'b1);
    count_done(10, np);
    chk("rec_done_cnt", 32'(np), 32'd1);
    chk("rec_err", 32'(bus0.err), 32'd0);
    host_rd("rec_ram7", 9'd7, 8'h34);
    host_rd("rec_ram100", 9'd100, 8'h57);

    // Timeout: controller never becomes ready
    bus0.sd_ready = 1'b0;
    tick(3);
    pulse_cmd(1'b1, 1'b0, 32'h50);
    tick(999);
    chk("tmo_early_err", 32'(bus0.err), 32'd0);
    chk("tmo_early_busy", 32'(bus0.busy), 32'd1);
    tick(1);
    chk("tmo_err", 32'(bus0.err), 32'd1);
    chk("tmo_busy", 32'(bus0.busy), 32'd0);
    chk("tmo_sd_rd", 32'(bus0.sd_rd), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
